// File: rtl/piso_serializer_32bit.sv
// Parallel-in/serial-out word serializer with a one-word holding register.
// Streams words gaplessly with word_start/word_done framing strobes.
module piso_serializer_32bit #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_start,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             transfer;
    logic             at_last;

    assign at_last    = (bit_cnt == LAST_BIT);
    assign data_ready = !hold_full && !reset;
    assign accept     = data_valid && data_ready;
    // Reload on the last bit of the current word keeps the stream gapless.
    assign transfer   = hold_full && ((state == IDLE) || at_last);

    always_comb begin
        shift_next = '0;
        if (MSB_FIRST) begin
            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
        end else begin
            shift_next = {1'b0, shift_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            if (accept) begin
                hold_reg  <= data_in;
                hold_full <= 1'b1;
            end
            if (transfer) begin
                shift_reg <= hold_reg;
                hold_full <= 1'b0;
                bit_cnt   <= '0;
                state     <= SHIFT;
            end else if (state == SHIFT) begin
                shift_reg <= shift_next;
                if (at_last) begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        word_start   = 1'b0;
        word_done    = 1'b0;
        if (state == SHIFT) begin
            serial_out   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
            serial_valid = 1'b1;
            word_start   = (bit_cnt == '0);
            word_done    = at_last;
        end
    end

    assign busy = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_piso_serializer_32bit.sv
// Scoreboard bench for piso_serializer_32bit: MSB-first instance checked bit by bit,
// plus an LSB-first instance for the reversed bit order.
module tb_piso_serializer_32bit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready, serial_out, serial_valid, word_start, word_done, busy;

    logic [31:0] lsb_data_in = '0;
    logic        lsb_data_valid = 1'b0;
    logic        lsb_data_ready, lsb_serial_out, lsb_serial_valid;
    logic        lsb_word_start, lsb_word_done, lsb_busy;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    typedef struct packed {
        logic b;
        logic s;
        logic d;
    } exp_bit_t;

    exp_bit_t    exp_q[$];
    logic [31:0] word_q[$];
    logic [31:0] sipo = '0;
    logic        rst_at_edge = 1'b0;

    always #5 clock = ~clock;

    piso_serializer_32bit #(.WIDTH(32), .MSB_FIRST(1'b1)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .serial_out(serial_out), .serial_valid(serial_valid),
        .word_start(word_start), .word_done(word_done), .busy(busy)
    );

    piso_serializer_32bit #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .data_in(lsb_data_in), .data_valid(lsb_data_valid),
        .data_ready(lsb_data_ready), .serial_out(lsb_serial_out), .serial_valid(lsb_serial_valid),
        .word_start(lsb_word_start), .word_done(lsb_word_done), .busy(lsb_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) rst_at_edge <= reset;

    // Monitor: compare current output against the scoreboard, then record new acceptances.
    always @(negedge clock) begin
        exp_bit_t e;
        if (rst_at_edge) begin
            check_eq("rst_outputs", {serial_out, serial_valid, word_start, word_done, busy}, '0);
            check_eq("rst_ready", data_ready, !reset);
            check_eq("rst_lsb_valid", {lsb_serial_valid, lsb_busy}, '0);
        end else if (serial_valid) begin
            check_eq("busy_while_shift", busy, 1'b1);
            if (word_start) check_eq("ready_after_xfer", data_ready, 1'b1);
            if (exp_q.size() == 0) begin
                check_eq("spurious_bit", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("serial_bit", serial_out, e.b);
                check_eq("word_start", word_start, e.s);
                check_eq("word_done", word_done, e.d);
                sipo = {sipo[30:0], serial_out};
                if (word_done && word_q.size() > 0) check_eq("sipo_word", sipo, word_q.pop_front());
            end
        end else begin
            check_eq("idle_outputs", {serial_out, word_start, word_done}, '0);
        end

        if (reset) begin
            exp_q.delete();
            word_q.delete();
        end else if (data_valid && data_ready) begin
            for (int i = 0; i < 32; i++) begin
                e.b = data_in[31-i];
                e.s = (i == 0);
                e.d = (i == 31);
                exp_q.push_back(e);
            end
            word_q.push_back(data_in);
        end
    end

    task automatic send_word(input logic [31:0] w);
        int unsigned n;
        n = 0;
        data_in = w;
        data_valid = 1'b1;
        @(negedge clock);
        while (!data_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!data_ready) check_eq("send_timeout", 1'b0, 1'b1);
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        data_in = $urandom;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        @(negedge clock);
        while (busy && n < 400) begin
            @(negedge clock);
            n++;
        end
        check_eq("drain_idle", busy, 1'b0);
        check_eq("sb_empty", exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int unsigned n;
        int unsigned vcnt, scnt, dcnt;
        logic [63:0] cap;

        // Reset held for two edges; monitor checks outputs and data_ready.
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single word, MSB first.
        send_word(32'hA5A5_0F0F);
        wait_idle();

        // Back-to-back words: 64 consecutive valid bits.
        vcnt = 0; scnt = 0; dcnt = 0; cap = '0;
        fork
            begin
                send_word(32'hFFFF_0000);
                send_word(32'h0000_FFFF);
            end
            begin
                n = 0;
                @(negedge clock);
                while (!serial_valid && n < 50) begin
                    @(negedge clock);
                    n++;
                end
                for (int i = 0; i < 64; i++) begin
                    vcnt += serial_valid;
                    scnt += word_start;
                    dcnt += word_done;
                    cap = {cap[62:0], serial_out};
                    @(negedge clock);
                end
                check_eq("b2b_valid_cycles", vcnt, 64);
                check_eq("b2b_starts", scnt, 2);
                check_eq("b2b_dones", dcnt, 2);
                check_eq("b2b_pattern", cap, 64'hFFFF_0000_0000_FFFF);
                check_eq("b2b_end_idle", serial_valid, 1'b0);
            end
        join
        wait_idle();

        // Backpressure: three more words presented while the first shifts.
        send_word(32'h1111_2222);
        send_word(32'h3333_4444);
        @(negedge clock);
        check_eq("bp_ready_low", data_ready, 1'b0);
        send_word(32'h5555_6666);
        send_word(32'h7777_8888);
        wait_idle();

        // Reset at bit 10 with a second word held.
        send_word(32'hDEAD_BEEF);
        send_word(32'hCAFE_F00D);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("no_resume_after_rst", serial_valid, 1'b0);
        send_word(32'h1234_5678);
        wait_idle();

        // LSB-first instance.
        lsb_data_in = 32'h0000_0001;
        lsb_data_valid = 1'b1;
        @(posedge clock);
        #1;
        lsb_data_valid = 1'b0;
        n = 0;
        @(negedge clock);
        while (!lsb_word_start && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_eq("lsb_start_seen", lsb_word_start, 1'b1);
        for (int i = 0; i < 32; i++) begin
            check_eq("lsb_bit", lsb_serial_out, (i == 0));
            check_eq("lsb_done", lsb_word_done, (i == 31));
            @(negedge clock);
        end
        check_eq("lsb_idle", lsb_serial_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
